twiddle_coeff_seq: RTL



---
 rtl/twiddle_coeff_seq.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/twiddle_coeff_seq.sv
// Radix-2 DIF twiddle-factor sequencer: streams LANES coefficients W_N^k per beat, stage by stage,
// from a quarter-wave cosine ROM, with a valid/ready output handshake.
module twiddle_coeff_seq #(
  parameter int unsigned NBITS = 9,
  parameter int unsigned N     = 8,
  parameter int unsigned LANES = 4,
  localparam int unsigned S    = $clog2(N),
  localparam int unsigned SW   = (S > 1) ? $clog2(S) : 1,
  localparam int unsigned CW   = 2 * NBITS * LANES
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic          out_ready_i,
  output logic          out_valid_o,
  output logic [CW-1:0] coeff_data_o,
  output logic [SW-1:0] stage_idx_o,
  output logic          last_beat_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam int unsigned B     = N / (2 * LANES);
  localparam int unsigned BW    = (B > 1) ? $clog2(B) : 1;
  localparam int unsigned Q     = N / 4;
  localparam int unsigned RomW  = (Q + 1) * NBITS;
  localparam longint      PiQ28 = 64'sd843314857;

  // Cosine evaluated by Taylor series in Q28 fixed point, rounded half away from zero
  // (all entries are non-negative on the quarter wave).
  function automatic logic [RomW-1:0] build_rom();
    logic [RomW-1:0] rom;
    longint x, x2, term, sum, val;
    rom = '0;
    for (int unsigned m = 0; m <= Q; m++) begin
      x    = (64'sd2 * longint'(m) * PiQ28) / longint'(N);
      x2   = (x * x) >>> 28;
      term = 64'sd1 <<< 28;
      sum  = term;
      for (int i = 1; i <= 10; i++) begin
        term = -(((term * x2) >>> 28) / longint'((2 * i - 1) * (2 * i)));
        sum  = sum + term;
      end
      val = ((sum <<< (NBITS - 2)) + (64'sd1 <<< 27)) >>> 28;
      rom[m*NBITS +: NBITS] = val[NBITS-1:0];
    end
    return rom;
  endfunction

  localparam logic [RomW-1:0] CosRom = build_rom();

  function automatic logic [NBITS-1:0] cos_rd(input int unsigned idx);
    return CosRom[idx*NBITS +: NBITS];
  endfunction

  function automatic logic [CW-1:0] gen_beat(input logic [SW-1:0] s, input logic [BW-1:0] b);
    logic [CW-1:0]    beat;
    logic [NBITS-1:0] re, im;
    int unsigned      j, k, mask;
    beat = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      j    = 32'(b) * LANES + l;
      mask = (N >> (32'(s) + 1)) - 1;
      k    = (j & mask) << s;
      if (k <= Q) begin
        re = cos_rd(k);
        im = '0 - cos_rd(Q - k);
      end else begin
        re = '0 - cos_rd(N / 2 - k);
        im = '0 - cos_rd(k - Q);
      end
      beat[2*NBITS*l +: 2*NBITS] = {im, re};
    end
    return beat;
  endfunction

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic [CW-1:0] coeff_q, coeff_d;
  logic          load;

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    beat_d  = beat_q;
    valid_d = valid_q;
    last_d  = last_q;
    coeff_d = coeff_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRun;
          stage_d = '0;
          beat_d  = '0;
          valid_d = 1'b1;
          load    = 1'b1;
        end
      end
      StRun: begin
        if (valid_q && out_ready_i) begin
          if (last_q) begin
            state_d = StDone;
            stage_d = '0;
            beat_d  = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            coeff_d = '0;
          end else begin
            if (beat_q == BW'(B - 1)) begin
              beat_d  = '0;
              stage_d = stage_q + SW'(1);
            end else begin
              beat_d = beat_q + BW'(1);
            end
            load = 1'b1;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Next beat is registered on the accepting edge, giving one beat per cycle.
    if (load) begin
      coeff_d = gen_beat(stage_d, beat_d);
      last_d  = (stage_d == SW'(S - 1)) && (beat_d == BW'(B - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      stage_q <= '0;
      beat_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      coeff_q <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      coeff_q <= coeff_d;
    end
  end

  assign out_valid_o  = valid_q;
  assign coeff_data_o = coeff_q;
  assign stage_idx_o  = stage_q;
  assign last_beat_o  = last_q;
  assign busy_o       = (state_q == StRun);
  assign done_o       = (state_q == StDone);

endmodule
